// File: rtl/reg_cut_tmo.sv
// Register-interface cut: one outstanding transaction, every output registered,
// with an optional watchdog that completes a hung access with an error response.

package reg_cut_tmo_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic          ready;
    logic [DW-1:0] rdata;
    logic          error;
  } reg_rsp_t;
endpackage

module reg_cut_tmo
  import reg_cut_tmo_pkg::*;
#(
  parameter logic        Bypass        = 1'b0,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t req_i,
  output rsp_t rsp_o,
  output req_t req_o,
  input  rsp_t rsp_i,
  output logic timeout_o,
  output logic busy_o
);

  if (Bypass) begin : g_bypass
    assign req_o     = req_i;
    assign rsp_o     = rsp_i;
    assign timeout_o = 1'b0;
    assign busy_o    = 1'b0;
  end else begin : g_cut
    typedef enum logic [1:0] {IDLE, REQ, RSP, DRAIN} state_e;

    state_e state_q, state_d;
    req_t   req_q, req_d;
    rsp_t   rsp_q, rsp_d;
    logic   timeout_q, timeout_d;
    logic   busy_q, busy_d;
    logic   tmo_hit;

    if (TimeoutCycles != 0) begin : g_wdog
      localparam int unsigned CW = $clog2(TimeoutCycles + 1);
      localparam logic [CW-1:0] CntLast = CW'(TimeoutCycles - 1);
      localparam logic [CW-1:0] CntMax  = {CW{1'b1}};

      logic [CW-1:0] cnt_q, cnt_d;

      // Cleared whenever not waiting, so it is zero on the first REQ cycle.
      always_comb begin
        cnt_d = cnt_q;
        if (state_q != REQ) begin
          cnt_d = '0;
        end else if (!rsp_i.ready && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign tmo_hit = (state_q == REQ) && (cnt_q == CntLast);
    end else begin : g_no_wdog
      assign tmo_hit = 1'b0;
    end

    always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      rsp_d         = rsp_q;
      rsp_d.ready   = 1'b0;
      timeout_d     = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i.valid) begin
            req_d   = req_i;
            state_d = REQ;
          end
        end
        REQ: begin
          // A real response wins over a watchdog expiry in the same cycle.
          if (rsp_i.ready) begin
            rsp_d.ready = 1'b1;
            rsp_d.rdata = rsp_i.rdata;
            rsp_d.error = rsp_i.error;
            state_d     = RSP;
          end else if (tmo_hit) begin
            rsp_d.ready = 1'b1;
            rsp_d.rdata = '0;
            rsp_d.error = 1'b1;
            timeout_d   = 1'b1;
            state_d     = DRAIN;
          end
        end
        RSP: begin
          state_d = IDLE;
        end
        DRAIN: begin
          // The late response is dropped; the downstream request stays up until then.
          if (rsp_i.ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      req_d.valid = (state_d == REQ) || (state_d == DRAIN);
      busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= IDLE;
        req_q     <= '0;
        rsp_q     <= '0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        req_q     <= req_d;
        rsp_q     <= rsp_d;
        timeout_q <= timeout_d;
        busy_q    <= busy_d;
      end
    end

    assign req_o     = req_q;
    assign rsp_o     = rsp_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;
  end

endmodule

// File: tb/tb_reg_cut_tmo.sv
// Bench for reg_cut_tmo: directed vectors with a response scoreboard, plus a bypass instance.
module tb_reg_cut_tmo;
  import reg_cut_tmo_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  reg_req_t req_i, req_o;
  reg_rsp_t rsp_i, rsp_o;
  logic     timeout, busy;

  reg_req_t b_req_i, b_req_o;
  reg_rsp_t b_rsp_i, b_rsp_o;
  logic     b_timeout, b_busy;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ready_c;
    logic [31:0] slv_rd;
    logic        slv_err;
    int          exp_c;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          tmo_c;
    int          busy_last;
  } vec_t;

  reg_cut_tmo #(.Bypass(1'b0), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .rsp_o(rsp_o),
    .req_o(req_o), .rsp_i(rsp_i), .timeout_o(timeout), .busy_o(busy)
  );

  reg_cut_tmo #(.Bypass(1'b1), .TimeoutCycles(0)) dut_byp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req_i), .rsp_o(b_rsp_o),
    .req_o(b_req_o), .rsp_i(b_rsp_i), .timeout_o(b_timeout), .busy_o(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_o.ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rsp_unexpected cycle=%0d actual=ready required=no_response", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn: rsp cycle=%0d rdata=0x%08h error=%0b (expected cycle=%0d rdata=0x%08h error=%0b)",
                 cyc, rsp_o.rdata, rsp_o.error, e.cyc, e.rdata, e.err);
        chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
        chk("rsp_rdata", 128'(rsp_o.rdata), 128'(e.rdata));
        chk("rsp_error", 128'(rsp_o.error), 128'(e.err));
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int base;
    int end_c;
    exp_t e;
    base  = 0;
    end_c = (v.ready_c > v.exp_c) ? v.ready_c : v.exp_c;
    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        base    = cyc;
        e.cyc   = base + v.exp_c;
        e.rdata = v.exp_rd;
        e.err   = v.exp_err;
        sb.push_back(e);
      end
      req_i.valid = (c <= v.exp_c);
      req_i.addr  = v.addr;
      req_i.write = v.wr;
      req_i.wdata = v.wdata;
      req_i.wstrb = v.wstrb;
      rsp_i.ready = (c == v.ready_c);
      rsp_i.rdata = (c == v.ready_c) ? v.slv_rd : 32'h0;
      rsp_i.error = (c == v.ready_c) ? v.slv_err : 1'b0;
      @(negedge clk);
      chk("req_valid", 128'(req_o.valid), 128'(c >= 1 && c <= v.ready_c));
      chk("busy", 128'(busy), 128'(c >= 1 && c <= v.busy_last));
      chk("timeout", 128'(timeout), 128'(c == v.tmo_c));
      if (c == 1)
        chk("req_fields", 128'({req_o.addr, req_o.write, req_o.wdata, req_o.wstrb}),
            128'({v.addr, v.wr, v.wdata, v.wstrb}));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_i = '0;
      rsp_i = '0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    //           wr    addr         wdata         strb  rdy slave_rd      serr exp rd_exp        eerr tmo busy
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF,  1, 32'h0,        1'b0, 2, 32'h0,        1'b0, -1, 2};
    vecs[1] = '{1'b0, 32'h24, 32'h0,        4'h0,  4, 32'hCAFE0001, 1'b0, 5, 32'hCAFE0001, 1'b0, -1, 5};
    vecs[2] = '{1'b0, 32'h30, 32'h0,        4'h0, 20, 32'h12345678, 1'b0, 9, 32'h0,        1'b1,  9, 20};
    vecs[3] = '{1'b1, 32'h40, 32'h11112222, 4'h3,  1, 32'h0,        1'b1, 2, 32'h0,        1'b1, -1, 2};
    vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h0,  1, 32'hA5A5A5A5, 1'b0, 2, 32'hA5A5A5A5, 1'b0, -1, 2};
    vecs[5] = '{1'b0, 32'h48, 32'h0,        4'h0,  2, 32'h5A5A0000, 1'b0, 3, 32'h5A5A0000, 1'b0, -1, 3};
    vecs[6] = '{1'b0, 32'h4C, 32'h0,        4'h0,  8, 32'h0BADF00D, 1'b0, 9, 32'h0BADF00D, 1'b0, -1, 9};
    vecs[7] = '{1'b0, 32'h50, 32'h0,        4'h0,  9, 32'h77777777, 1'b0, 9, 32'h0,        1'b1,  9, 9};

    req_i = '0;
    rsp_i = '0;
    b_req_i = '0;
    b_rsp_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 128'(req_o.valid), 128'(0));
    chk("rst_rsp", 128'(rsp_o), 128'(0));
    chk("rst_flags", 128'({timeout, busy}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Single transactions, then a back-to-back burst with no gaps.
    for (int i = 0; i < 3; i++) begin
      run_txn(vecs[i]);
      idle_cycles(2);
    end
    for (int i = 3; i < 8; i++) run_txn(vecs[i]);
    idle_cycles(3);

    // Reset while the slave is stalled: the access vanishes without a response.
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk);
      #1;
      req_i.valid = 1'b1;
      req_i.addr  = 32'h60;
      req_i.write = 1'b0;
      rsp_i       = '0;
      if (c == 3) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_req_valid", 128'(req_o.valid), 128'(0));
        chk("rstmid_busy", 128'(busy), 128'(0));
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_i = '0;
    idle_cycles(1);
    run_txn(vecs[1]);
    idle_cycles(3);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    // Bypass instance: outputs must follow inputs combinationally.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      b_req_i.valid = 1'($urandom);
      b_req_i.addr  = $urandom;
      b_req_i.write = 1'($urandom);
      b_req_i.wdata = $urandom;
      b_req_i.wstrb = 4'($urandom);
      b_rsp_i.ready = 1'($urandom);
      b_rsp_i.rdata = $urandom;
      b_rsp_i.error = 1'($urandom);
      @(negedge clk);
      chk("byp_req", 128'(b_req_o), 128'(b_req_i));
      chk("byp_rsp", 128'(b_rsp_o), 128'(b_rsp_i));
      chk("byp_flags", 128'({b_timeout, b_busy}), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
